// File: rtl/apb_interconnect.sv
// apb_interconnect
//   Single-master to six-slave APB-style address decoder and router.
//   addr_in[11:8] selects the slave (0x0..0x5 -> slave 1..6). Regions
//   0x6..0xF are unmapped, and their transfers are dropped silently.
//   The selected bundle is registered with the full address, the write
//   strobe and the write data. Reads forward zero data.
//   All other bundles are registered to zero, so at most one bundle is
//   non-zero in any cycle.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   addr_in[11:0]         master address
//   wr_in                 1 = write, 0 = read
//   sel                   master select (transfer valid)
//   data_in[31:0]         master write data
//   wr_outN               write strobe to slave N (N = 1..6)
//   addr_outN[11:0]       address forwarded to slave N
//   data_outN[31:0]       write data forwarded to slave N
module apb_interconnect (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] addr_in,
  input  logic        wr_in,
  input  logic        sel,
  input  logic [31:0] data_in,
  output logic        wr_out1,
  output logic [11:0] addr_out1,
  output logic [31:0] data_out1,
  output logic        wr_out2,
  output logic [11:0] addr_out2,
  output logic [31:0] data_out2,
  output logic        wr_out3,
  output logic [11:0] addr_out3,
  output logic [31:0] data_out3,
  output logic        wr_out4,
  output logic [11:0] addr_out4,
  output logic [31:0] data_out4,
  output logic        wr_out5,
  output logic [11:0] addr_out5,
  output logic [31:0] data_out5,
  output logic        wr_out6,
  output logic [11:0] addr_out6,
  output logic [31:0] data_out6
);

  logic [3:0]  region;
  logic [5:0]  hit;
  logic [5:0]  wr_q;
  logic [11:0] addr_q [6];
  logic [31:0] data_q [6];

  assign region = addr_in[11:8];

  // Only one hit bit can be set because each slave matches a distinct
  // region value. Unmapped regions leave every bit clear.
  genvar g;
  generate
    for (g = 0; g < 6; g++) begin : g_slave
      assign hit[g] = sel && (region == 4'(g));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          wr_q[g]   <= 1'b0;
          addr_q[g] <= 12'h000;
          data_q[g] <= 32'h0;
        end else if (hit[g]) begin
          wr_q[g]   <= wr_in;
          addr_q[g] <= addr_in;
          data_q[g] <= wr_in ? data_in : 32'h0;
        end else begin
          wr_q[g]   <= 1'b0;
          addr_q[g] <= 12'h000;
          data_q[g] <= 32'h0;
        end
      end
    end
  endgenerate

  assign wr_out1   = wr_q[0];
  assign addr_out1 = addr_q[0];
  assign data_out1 = data_q[0];
  assign wr_out2   = wr_q[1];
  assign addr_out2 = addr_q[1];
  assign data_out2 = data_q[1];
  assign wr_out3   = wr_q[2];
  assign addr_out3 = addr_q[2];
  assign data_out3 = data_q[2];
  assign wr_out4   = wr_q[3];
  assign addr_out4 = addr_q[3];
  assign data_out4 = data_q[3];
  assign wr_out5   = wr_q[4];
  assign addr_out5 = addr_q[4];
  assign data_out5 = data_q[4];
  assign wr_out6   = wr_q[5];
  assign addr_out6 = addr_q[5];
  assign data_out6 = data_q[5];

endmodule

// File: tb/tb_apb_interconnect.sv
// tb_apb_interconnect
//   Directed bench for apb_interconnect. Inputs are driven on the falling
//   edge. Outputs are sampled 1 ns after the rising edge. All 18 outputs
//   are compared against hand-computed bundles.
module tb_apb_interconnect;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] addr_in;
  logic        wr_in;
  logic        sel;
  logic [31:0] data_in;

  logic        wr_out1, wr_out2, wr_out3, wr_out4, wr_out5, wr_out6;
  logic [11:0] addr_out1, addr_out2, addr_out3, addr_out4, addr_out5, addr_out6;
  logic [31:0] data_out1, data_out2, data_out3, data_out4, data_out5, data_out6;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  apb_interconnect dut (
    .clk(clk), .rst(rst), .addr_in(addr_in), .wr_in(wr_in), .sel(sel), .data_in(data_in),
    .wr_out1(wr_out1), .addr_out1(addr_out1), .data_out1(data_out1),
    .wr_out2(wr_out2), .addr_out2(addr_out2), .data_out2(data_out2),
    .wr_out3(wr_out3), .addr_out3(addr_out3), .data_out3(data_out3),
    .wr_out4(wr_out4), .addr_out4(addr_out4), .data_out4(data_out4),
    .wr_out5(wr_out5), .addr_out5(addr_out5), .data_out5(data_out5),
    .wr_out6(wr_out6), .addr_out6(addr_out6), .data_out6(data_out6)
  );

  logic        wr_o   [1:6];
  logic [11:0] addr_o [1:6];
  logic [31:0] data_o [1:6];

  assign wr_o[1] = wr_out1;  assign addr_o[1] = addr_out1;  assign data_o[1] = data_out1;
  assign wr_o[2] = wr_out2;  assign addr_o[2] = addr_out2;  assign data_o[2] = data_out2;
  assign wr_o[3] = wr_out3;  assign addr_o[3] = addr_out3;  assign data_o[3] = data_out3;
  assign wr_o[4] = wr_out4;  assign addr_o[4] = addr_out4;  assign data_o[4] = data_out4;
  assign wr_o[5] = wr_out5;  assign addr_o[5] = addr_out5;  assign data_o[5] = data_out5;
  assign wr_o[6] = wr_out6;  assign addr_o[6] = addr_out6;  assign data_o[6] = data_out6;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // Slave n (1..6) must carry w/a/d and every other bundle must be zero.
  // n = 0 expects all six bundles to be zero.
  task automatic expect_out(input string tag, input int n, input logic w,
                            input logic [11:0] a, input logic [31:0] d);
    for (int i = 1; i <= 6; i++) begin
      chk($sformatf("%s wr%0d", tag, i),   {31'h0, wr_o[i]}, (i == n) ? {31'h0, w} : 32'h0);
      chk($sformatf("%s addr%0d", tag, i), {20'h0, addr_o[i]}, (i == n) ? {20'h0, a} : 32'h0);
      chk($sformatf("%s data%0d", tag, i), data_o[i], (i == n) ? d : 32'h0);
    end
  endtask

  task automatic drive(input logic s, input logic w, input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    sel = s; wr_in = w; addr_in = a; data_in = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; sel = 1'b1; wr_in = 1'b1; addr_in = 12'h000; data_in = 32'd4;

    // Reset holds every output at zero even with a valid transfer present.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      expect_out($sformatf("reset%0d", k), 0, 1'b0, 12'h0, 32'h0);
    end

    // Release reset; the first edge afterwards samples the pending write.
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    expect_out("rel", 1, 1'b1, 12'h000, 32'd4);

    drive(1'b1, 1'b1, 12'h300, 32'd13);
    expect_out("route4", 4, 1'b1, 12'h300, 32'd13);

    drive(1'b1, 1'b1, 12'h2C4, 32'hA5A5_0003);
    expect_out("route3", 3, 1'b1, 12'h2C4, 32'hA5A5_0003);

    // Back-to-back: write slave 5, then read slave 6 (read data forced to 0).
    drive(1'b1, 1'b1, 12'h400, 32'd18);
    expect_out("b2b5", 5, 1'b1, 12'h400, 32'd18);
    drive(1'b1, 1'b0, 12'h500, 32'd9);
    expect_out("b2b6", 6, 1'b0, 12'h500, 32'h0);

    drive(1'b1, 1'b1, 12'h600, 32'd6);
    expect_out("unmap6", 0, 1'b0, 12'h0, 32'h0);
    drive(1'b1, 1'b1, 12'hF12, 32'd7);
    expect_out("unmapF", 0, 1'b0, 12'h0, 32'h0);

    drive(1'b0, 1'b1, 12'h100, 32'hDEAD_BEEF);
    expect_out("desel", 0, 1'b0, 12'h0, 32'h0);

    // Read at the top of region 5 and write into slave 2.
    drive(1'b1, 1'b0, 12'h5FF, 32'h1234_5678);
    expect_out("rd6top", 6, 1'b0, 12'h5FF, 32'h0);
    drive(1'b1, 1'b1, 12'h1AB, 32'h0000_0055);
    expect_out("route2", 2, 1'b1, 12'h1AB, 32'h0000_0055);

    // Input changes between edges must not reach the outputs.
    sel = 1'b1; wr_in = 1'b1; addr_in = 12'h0EE; data_in = 32'h0BAD_F00D;
    #2;
    expect_out("nocomb", 2, 1'b1, 12'h1AB, 32'h0000_0055);

    // Reset asserted mid-cycle clears the outputs before the next edge.
    #1;
    rst = 1'b1;
    #1;
    expect_out("async", 0, 1'b0, 12'h0, 32'h0);
    @(posedge clk);
    #1;
    expect_out("async_hold", 0, 1'b0, 12'h0, 32'h0);

    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b1, 12'h0FF, 32'hCAFE_0001);
    expect_out("post1", 1, 1'b1, 12'h0FF, 32'hCAFE_0001);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_interconnect.md
# apb_interconnect

Single-master to six-slave APB-style address decoder and router. A transfer presented on the master side is decoded by its upper address nibble and forwarded, registered, onto exactly one of six slave output bundles. Non-selected slave bundles are driven to zero. The block sits between the system bus master and the peripheral set of the SoC.

## Interface
- No parameters; widths fixed: address 12 bits, data 32 bits, 6 slave ports.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- addr_in  input  12  master address; addr_in[11:8] selects the slave.
- wr_in  input  1  1 = write, 0 = read.
- sel  input  1  master select; transfer valid when 1.
- data_in  input  32  master write data.
- wr_outN  output  1  write strobe to slave N (N = 1..6).
- addr_outN  output  12  full address forwarded to slave N.
- data_outN  output  32  write data forwarded to slave N.

## Operation
- Decode: region = addr_in[11:8]. Region 0x0 -> slave 1, 0x1 -> slave 2, 0x2 -> slave 3, 0x3 -> slave 4, 0x4 -> slave 5, 0x5 -> slave 6. Regions 0x6–0xF are unmapped.
- Transfer accepted on a rising clk edge when sel=1 and the region is mapped.
- Selected slave N, registered at that edge:
  - addr_outN = addr_in, full 12 bits with no offset stripping.
  - wr_outN = wr_in.
  - data_outN = data_in when wr_in=1; 32'h0 when wr_in=0 (read).
- All other five slave bundles are registered to zero at the same edge (wr=0, addr=0, data=0).
- sel=0 or unmapped region: all six bundles are registered to zero. No error indication; the transfer is dropped.
- At most one slave bundle is non-zero in any cycle (one-hot routing).
- No ready/wait handling. Every accepted transfer occupies exactly one cycle, and back-to-back transfers to different slaves are allowed every cycle.

## Timing
- Reset: while rst=1, every wr_outN, addr_outN and data_outN is 0. Outputs are forced immediately (asynchronous), independent of clk.
- Reset release: the first rising edge with rst=0 samples inputs normally.
- Latency: 1 cycle. Inputs sampled at edge k appear on outputs after edge k and hold until edge k+1.
- Outputs are purely registered, with no combinational path from inputs to outputs.
- Reset asserted mid-transfer: outputs clear at once and the in-flight transfer is lost.
- Input changes between edges have no effect on outputs.

## Test plan
- Reset: assert rst=1 with sel=1, addr_in=0x000, wr_in=1, data_in=4 -> all 18 outputs stay 0 across multiple edges. Release rst -> next edge gives wr_out1=1, addr_out1=0x000, data_out1=4; others 0.
- Routing: after reset release, drive sel=1, wr_in=1, addr_in=0x300, data_in=13 -> after one edge wr_out4=1, addr_out4=0x300, data_out4=13; the other five bundles are 0.
- Back-to-back: write 0x400/data 18, then a read at 0x500/data 9 on consecutive cycles:
  - first cycle -> slave 5 gets wr=1, data=18.
  - next cycle -> slave 6 gets wr=0, addr=0x500, data=0, and slave 5 returns to all-zero.
- Unmapped: sel=1, wr_in=1, addr_in=0x600, data_in=6 -> all outputs 0 after the edge.
- Deselect: sel=0 with addr_in=0x100, data_in=0xDEADBEEF, wr_in=1 -> all outputs 0.
- Async reset mid-operation: assert rst between edges while slave 2 is active -> outputs clear before the next clock edge.
